control_unit_mw: RTL and testbench

Parametrised multicycle control FSM for the 16-opcode accumulator/stack CPU. It is the next generation of the existing controller. Every memory-touching state now waits on a request/ready handshake with the memory, and an optional watchdog bounds that wait. Undefined opcodes and memory timeouts divert to a trap state, and a retired-instruction counter is provided. It sits between the instruction register/opcode decode and the datapath, driving all datapath strobes combinationally from the registered state.

---
 rtl/control_unit_mw.sv | 157 +++++++++++++++
 tb/tb_control_unit_mw.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mw.sv
// Multicycle control FSM for the 16-opcode accumulator/stack CPU: one-hot state,
// handshaked memory waits with an optional watchdog, trap state and retire counter.
module control_unit_mw #(
    parameter int CNT_W   = 16,
    parameter int MEM_TO  = 255,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       Op,
    input  logic             LMC,
    input  logic             Perform,
    input  logic             MemRdy,
    output logic             MemReq,
    output logic             PCW,
    output logic             Jump,
    output logic             MW,
    output logic             LM,
    output logic             IW,
    output logic             IorD,
    output logic             MSrc,
    output logic             RW,
    output logic             SrcB,
    output logic             FU,
    output logic             SPW,
    output logic             SPIorD,
    output logic [2:0]       RWSrc,
    output logic [2:0]       ALUOp,
    output logic             TrapPC,
    output logic             Trap,
    output logic [1:0]       TrapCause,
    output logic [CNT_W-1:0] Retired,
    output logic [9:1]       s
);
    typedef enum logic [9:1] {
        S1 = 9'h001, S2 = 9'h002, S3 = 9'h004, S4 = 9'h008, S5 = 9'h010,
        S6 = 9'h020, S7 = 9'h040, S8 = 9'h080, S9 = 9'h100
    } state_e;

    localparam logic [3:0] OP_ADDI = 4'h1, OP_STO = 4'h2, OP_LUI = 4'h3, OP_CMP = 4'h5;
    localparam logic [3:0] OP_CP = 4'h6, OP_CPI = 4'h7, OP_PUSH = 4'hA, OP_POP = 4'hB;
    localparam logic [3:0] OP_ILL = 4'hD, OP_JR = 4'hE, OP_J = 4'hF;

    // Counter only has to reach MEM_TO-1: the timeout fires on the last wait cycle.
    localparam int TO_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

    state_e            state_q, state_d, st;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [1:0]        cause_q, cause_d;
    logic              rdy, waiting, timed_out, retire, trap_ill;

    always_comb begin
        // While RESET is high the outputs look like a fresh fetch with no handshake.
        st        = RESET ? S1 : state_q;
        rdy       = MemRdy & ~RESET;
        MemReq = 1'b0; PCW = 1'b0; Jump = 1'b0; MW = 1'b0; LM = 1'b0; IW = 1'b0;
        IorD = 1'b0; MSrc = 1'b0; RW = 1'b0; SrcB = 1'b0; FU = 1'b0; SPW = 1'b0;
        SPIorD = 1'b0; RWSrc = 3'b000; ALUOp = 3'b000; TrapPC = 1'b0; Trap = 1'b0;
        state_d   = S1;
        waiting   = 1'b0;
        retire    = 1'b0;
        trap_ill  = 1'b0;
        timed_out = (MEM_TO != 0) && (wait_cnt_q == TO_LAST) && !rdy;

        case (st)
            S1: begin
                MemReq = 1'b1; IorD = 1'b1; waiting = 1'b1;
                IW = rdy; PCW = rdy;
                state_d = rdy ? S2 : S1;
            end
            S2: begin
                if (!Perform) state_d = S1;
                else begin
                    case (Op)
                        OP_LUI:  begin RW = 1'b1; RWSrc = 3'b101; retire = 1'b1; state_d = S1; end
                        OP_CPI:  begin RW = 1'b1; RWSrc = 3'b111; retire = 1'b1; state_d = S1; end
                        OP_PUSH: begin SPW = 1'b1; state_d = S5; end
                        OP_POP: begin
                            MemReq = 1'b1; LM = 1'b1; waiting = 1'b1;
                            state_d = rdy ? S8 : S2;
                        end
                        OP_J: begin
                            MemReq = 1'b1; LM = 1'b1; IorD = 1'b1; waiting = 1'b1;
                            PCW = rdy;
                            state_d = rdy ? S7 : S2;
                        end
                        OP_ADDI: state_d = S4;
                        OP_STO:  state_d = LMC ? S3 : S5;
                        OP_CP:   state_d = LMC ? S3 : S6;
                        OP_JR:   state_d = LMC ? S3 : S7;
                        OP_ILL: begin
                            trap_ill = TRAP_EN;
                            state_d  = TRAP_EN ? S9 : S1;
                        end
                        default: state_d = LMC ? S3 : S4;
                    endcase
                end
            end
            S3: begin
                MemReq = 1'b1; LM = 1'b1; MSrc = 1'b1; waiting = 1'b1;
                if (!rdy)              state_d = S3;
                else if (Op == OP_STO) state_d = S5;
                else if (Op == OP_CP)  state_d = S6;
                else if (Op == OP_JR)  state_d = S7;
                else                   state_d = S4;
            end
            S4: begin
                ALUOp = {Op[3:2], Op[0]};
                SrcB  = (Op == OP_ADDI);
                FU    = (Op == OP_CMP);
                RW    = (Op != OP_CMP);
                retire = 1'b1;
            end
            S5: begin
                MemReq = 1'b1; MW = 1'b1; MSrc = (Op == OP_STO); waiting = 1'b1;
                retire  = rdy;
                state_d = rdy ? S1 : S5;
            end
            S6: begin RW = 1'b1; RWSrc = 3'b001; retire = 1'b1; end
            S7: begin
                PCW = 1'b1; Jump = 1'b1; retire = 1'b1;
                if (LMC && Op == OP_J) begin RW = 1'b1; RWSrc = 3'b011; end
            end
            S8: begin SPW = 1'b1; SPIorD = 1'b1; retire = 1'b1; end
            S9: begin Trap = 1'b1; PCW = 1'b1; TrapPC = 1'b1; end
            default: state_d = S1;
        endcase

        // Gated strobes are already low here since timed_out implies !rdy.
        if (waiting && timed_out) state_d = S9;

        // Any state change (including a completed handshake) restarts the wait count.
        wait_cnt_d = (waiting && state_d == st) ? wait_cnt_q + 1'b1 : '0;
        retired_d  = retired_q + CNT_W'(retire);
        cause_d    = (waiting && timed_out) ? 2'b10 : (trap_ill ? 2'b01 : cause_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S1;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            cause_q    <= cause_d;
        end
    end

    assign s         = state_q;
    assign Retired   = retired_q;
    assign TrapCause = cause_q;
endmodule

// File: tb/tb_control_unit_mw.sv
// Directed bench for control_unit_mw: a table of per-cycle vectors plus hand-built
// sequences for stalls, watchdog timeouts, traps, squashes and mid-wait reset.
module tb_control_unit_mw;
    logic       CLK = 1'b0;
    logic       RESET, LMC, Perform, MemRdy;
    logic [3:0] Op;

    logic MemReq, PCW, Jump, MW, LM, IW, IorD, MSrc, RW, SrcB, FU, SPW, SPIorD, TrapPC, Trap;
    logic [2:0] RWSrc, ALUOp;
    logic [1:0] TrapCause;
    logic [1:0] Retired;
    logic [9:1] s;

    logic MemReq_b, PCW_b, Jump_b, MW_b, LM_b, IW_b, IorD_b, MSrc_b, RW_b, SrcB_b, FU_b;
    logic SPW_b, SPIorD_b, TrapPC_b, Trap_b;
    logic [2:0]  RWSrc_b, ALUOp_b;
    logic [1:0]  TrapCause_b;
    logic [15:0] Retired_b;
    logic [9:1]  s_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    control_unit_mw #(.CNT_W(2), .MEM_TO(4), .TRAP_EN(1'b1)) u_dut (
        .CLK(CLK), .RESET(RESET), .Op(Op), .LMC(LMC), .Perform(Perform), .MemRdy(MemRdy),
        .MemReq(MemReq), .PCW(PCW), .Jump(Jump), .MW(MW), .LM(LM), .IW(IW), .IorD(IorD),
        .MSrc(MSrc), .RW(RW), .SrcB(SrcB), .FU(FU), .SPW(SPW), .SPIorD(SPIorD),
        .RWSrc(RWSrc), .ALUOp(ALUOp), .TrapPC(TrapPC), .Trap(Trap), .TrapCause(TrapCause),
        .Retired(Retired), .s(s)
    );

    // Second instance: illegal opcode is a NOP and the watchdog is disabled.
    control_unit_mw #(.CNT_W(16), .MEM_TO(0), .TRAP_EN(1'b0)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .Op(Op), .LMC(LMC), .Perform(Perform), .MemRdy(MemRdy),
        .MemReq(MemReq_b), .PCW(PCW_b), .Jump(Jump_b), .MW(MW_b), .LM(LM_b), .IW(IW_b),
        .IorD(IorD_b), .MSrc(MSrc_b), .RW(RW_b), .SrcB(SrcB_b), .FU(FU_b), .SPW(SPW_b),
        .SPIorD(SPIorD_b), .RWSrc(RWSrc_b), .ALUOp(ALUOp_b), .TrapPC(TrapPC_b),
        .Trap(Trap_b), .TrapCause(TrapCause_b), .Retired(Retired_b), .s(s_b)
    );

    logic [20:0] outs;
    assign outs = {MemReq, PCW, Jump, MW, LM, IW, IorD, MSrc, RW, SrcB, FU, SPW, SPIorD,
                   TrapPC, Trap, RWSrc, ALUOp};

    localparam logic [20:0] REQ  = 21'd1 << 20, PCWM = 21'd1 << 19, JMP  = 21'd1 << 18;
    localparam logic [20:0] MWM  = 21'd1 << 17, LMM  = 21'd1 << 16, IWM  = 21'd1 << 15;
    localparam logic [20:0] IORD = 21'd1 << 14, MSRC = 21'd1 << 13, RWM  = 21'd1 << 12;
    localparam logic [20:0] SRCB = 21'd1 << 11, FUM  = 21'd1 << 10, SPWM = 21'd1 << 9;
    localparam logic [20:0] SPID = 21'd1 << 8,  TPC  = 21'd1 << 7,  TRP  = 21'd1 << 6;
    localparam logic [20:0] F1   = REQ | IORD | IWM | PCWM;
    localparam logic [20:0] F1W  = REQ | IORD;
    localparam logic [20:0] TRAPO = TRP | PCWM | TPC;

    function automatic logic [20:0] rws(input logic [2:0] x);
        return {15'd0, x, 3'd0};
    endfunction
    function automatic logic [20:0] alu(input logic [2:0] x);
        return {18'd0, x};
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic        lmc, perf, rdy;
        logic [8:0]  s;
        logic [20:0] o;
        logic [1:0]  ret;
    } vec_t;

    function automatic vec_t v(input logic [3:0] op, input logic lmc, input logic perf,
                               input logic rdy, input logic [8:0] st, input logic [20:0] o,
                               input logic [1:0] ret);
        vec_t r;
        r.op = op; r.lmc = lmc; r.perf = perf; r.rdy = rdy; r.s = st; r.o = o; r.ret = ret;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle's inputs, check the current state and decoded outputs, then clock.
    task automatic apply(input string nm, input vec_t r);
        Op = r.op; LMC = r.lmc; Perform = r.perf; MemRdy = r.rdy;
        #2;
        chk({nm, " s"}, 32'(s), 32'(r.s));
        chk({nm, " outs"}, 32'(outs), 32'(r.o));
        chk({nm, " retired"}, 32'(Retired), 32'(r.ret));
        tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1; Op = 4'h0; LMC = 1'b0; Perform = 1'b1; MemRdy = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        // ADD ADDI SUB(LMC) CMP LUI CPI CP PUSH POP J(LMC) JR(LMC) STO AND XOR OR
        tbl.push_back(v(4'h0,0,1,1,9'h001,F1,0));  tbl.push_back(v(4'h0,0,1,1,9'h002,0,0));
        tbl.push_back(v(4'h0,0,1,1,9'h008,RWM|alu(0),0));
        tbl.push_back(v(4'h1,0,1,1,9'h001,F1,1));  tbl.push_back(v(4'h1,0,1,1,9'h002,0,1));
        tbl.push_back(v(4'h1,0,1,1,9'h008,RWM|SRCB|alu(1),1));
        tbl.push_back(v(4'h4,1,1,1,9'h001,F1,2));  tbl.push_back(v(4'h4,1,1,1,9'h002,0,2));
        tbl.push_back(v(4'h4,1,1,1,9'h004,REQ|LMM|MSRC,2));
        tbl.push_back(v(4'h4,1,1,1,9'h008,RWM|alu(2),2));
        tbl.push_back(v(4'h5,0,1,1,9'h001,F1,3));  tbl.push_back(v(4'h5,0,1,1,9'h002,0,3));
        tbl.push_back(v(4'h5,0,1,1,9'h008,FUM|alu(3),3));
        tbl.push_back(v(4'h3,0,1,1,9'h001,F1,0));  tbl.push_back(v(4'h3,0,1,1,9'h002,RWM|rws(5),0));
        tbl.push_back(v(4'h7,0,1,1,9'h001,F1,1));  tbl.push_back(v(4'h7,0,1,1,9'h002,RWM|rws(7),1));
        tbl.push_back(v(4'h6,0,1,1,9'h001,F1,2));  tbl.push_back(v(4'h6,0,1,1,9'h002,0,2));
        tbl.push_back(v(4'h6,0,1,1,9'h020,RWM|rws(1),2));
        tbl.push_back(v(4'hA,0,1,1,9'h001,F1,3));  tbl.push_back(v(4'hA,0,1,1,9'h002,SPWM,3));
        tbl.push_back(v(4'hA,0,1,1,9'h010,REQ|MWM,3));
        tbl.push_back(v(4'hB,0,1,1,9'h001,F1,0));  tbl.push_back(v(4'hB,0,1,1,9'h002,REQ|LMM,0));
        tbl.push_back(v(4'hB,0,1,1,9'h080,SPWM|SPID,0));
        tbl.push_back(v(4'hF,1,1,1,9'h001,F1,1));
        tbl.push_back(v(4'hF,1,1,1,9'h002,REQ|LMM|IORD|PCWM,1));
        tbl.push_back(v(4'hF,1,1,1,9'h040,PCWM|JMP|RWM|rws(3),1));
        tbl.push_back(v(4'hE,1,1,1,9'h001,F1,2));  tbl.push_back(v(4'hE,1,1,1,9'h002,0,2));
        tbl.push_back(v(4'hE,1,1,1,9'h004,REQ|LMM|MSRC,2));
        tbl.push_back(v(4'hE,1,1,1,9'h040,PCWM|JMP,2));
        tbl.push_back(v(4'h2,0,1,1,9'h001,F1,3));  tbl.push_back(v(4'h2,0,1,1,9'h002,0,3));
        tbl.push_back(v(4'h2,0,1,1,9'h010,REQ|MWM|MSRC,3));
        tbl.push_back(v(4'h8,0,1,1,9'h001,F1,0));  tbl.push_back(v(4'h8,0,1,1,9'h002,0,0));
        tbl.push_back(v(4'h8,0,1,1,9'h008,RWM|alu(4),0));
        tbl.push_back(v(4'h9,0,1,1,9'h001,F1,1));  tbl.push_back(v(4'h9,0,1,1,9'h002,0,1));
        tbl.push_back(v(4'h9,0,1,1,9'h008,RWM|alu(5),1));
        tbl.push_back(v(4'hC,0,1,1,9'h001,F1,2));  tbl.push_back(v(4'hC,0,1,1,9'h002,0,2));
        tbl.push_back(v(4'hC,0,1,1,9'h008,RWM|alu(6),2));
        tbl.push_back(v(4'h0,0,1,1,9'h001,F1,3));

        // Reset: outputs during reset look like S1 with no handshake strobes.
        RESET = 1'b1; Op = 4'h0; LMC = 1'b0; Perform = 1'b1; MemRdy = 1'b1;
        #2;
        chk("reset outs", 32'(outs), 32'(F1W));
        tick();
        RESET = 1'b0;
        chk("reset s", 32'(s), 32'h001);
        chk("reset retired", 32'(Retired), 0);
        chk("reset cause", 32'(TrapCause), 0);

        for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

        // STO with LMC and three stalled S5 cycles: 7 cycles total.
        do_reset();
        apply("sto f",  v(4'h2,1,1,1,9'h001,F1,0));
        apply("sto d",  v(4'h2,1,1,1,9'h002,0,0));
        apply("sto ld", v(4'h2,1,1,1,9'h004,REQ|LMM|MSRC,0));
        for (int i = 0; i < 3; i++) apply($sformatf("sto wait%0d", i), v(4'h2,1,1,0,9'h010,REQ|MWM|MSRC,0));
        apply("sto wr", v(4'h2,1,1,1,9'h010,REQ|MWM|MSRC,0));
        apply("sto end", v(4'hD,0,1,1,9'h001,F1,1));

        // Illegal opcode: trap on the main DUT, NOP on the TRAP_EN=0 DUT.
        apply("ill d", v(4'hD,0,1,1,9'h002,0,1));
        chk("ill nop s_b", 32'(s_b), 32'h001);
        chk("ill cause", 32'(TrapCause), 32'h1);
        apply("ill trap", v(4'hD,0,1,1,9'h100,TRAPO,1));
        apply("ill back", v(4'hA,0,1,1,9'h001,F1,1));
        chk("ill cause hold", 32'(TrapCause), 32'h1);

        // Reset in the middle of a PUSH write wait.
        apply("rst push d", v(4'hA,0,1,1,9'h002,SPWM,1));
        apply("rst wait0", v(4'hA,0,1,0,9'h010,REQ|MWM,1));
        apply("rst wait1", v(4'hA,0,1,0,9'h010,REQ|MWM,1));
        RESET = 1'b1;
        #2;
        chk("rst mid outs", 32'(outs), 32'(F1W));
        tick();
        RESET = 1'b0;
        chk("rst mid s", 32'(s), 32'h001);
        chk("rst mid retired", 32'(Retired), 0);
        chk("rst mid cause", 32'(TrapCause), 0);

        // Watchdog in fetch, then a handshake on exactly the last wait cycle.
        for (int i = 0; i < 4; i++) apply($sformatf("to f%0d", i), v(4'h0,0,1,0,9'h001,F1W,0));
        chk("to cause", 32'(TrapCause), 32'h2);
        chk("to nowdog s_b", 32'(s_b), 32'h001);
        apply("to trap", v(4'h0,0,1,0,9'h100,TRAPO,0));
        for (int i = 0; i < 3; i++) apply($sformatf("late f%0d", i), v(4'hB,0,1,0,9'h001,F1W,0));
        apply("late rdy", v(4'hB,0,1,1,9'h001,F1,0));
        // Watchdog during a POP read in decode.
        for (int i = 0; i < 4; i++) apply($sformatf("pop to%0d", i), v(4'hB,0,1,0,9'h002,REQ|LMM,0));
        apply("pop trap", v(4'h0,0,1,1,9'h100,TRAPO,0));
        chk("pop cause", 32'(TrapCause), 32'h2);

        // Perform=0 squashes at decode; dropping it in S4 has no effect.
        do_reset();
        apply("sq f",   v(4'h0,0,1,1,9'h001,F1,0));
        apply("sq d",   v(4'h0,0,0,1,9'h002,0,0));
        apply("sq f2",  v(4'h0,0,1,1,9'h001,F1,0));
        apply("sq d2",  v(4'h0,0,1,1,9'h002,0,0));
        apply("sq alu", v(4'h0,0,0,1,9'h008,RWM|alu(0),0));
        apply("sq end", v(4'h0,0,1,1,9'h001,F1,1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
